// File: rtl/io_hub_pkg.sv
// rtl/io_hub_pkg.sv - io_hub address map, register offsets and bit positions
package io_hub_pkg;

  localparam logic [21:0] IOHUB_HI = 22'h3FFFFF;

  localparam logic [9:0] IOHUB_LED_BASE = 10'h060;
  localparam logic [9:0] IOHUB_SW_BASE  = 10'h070;
  localparam logic [9:0] IOHUB_STATUS   = 10'h078;
  localparam logic [9:0] IOHUB_CTRL     = 10'h07C;

  localparam int ST_PENDING  = 0;
  localparam int ST_LEVEL    = 1;
  localparam int ST_IRQ_EN   = 2;
  localparam int ST_CNT_LSB  = 8;
  localparam int CTRL_CLR    = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/io_hub_btn_debounce.sv
// rtl/io_hub_btn_debounce.sv - button synchroniser and debouncer with rise pulse
module btn_debounce #(
  parameter int DEB_CYCLES = 200000
) (
  input  logic clock,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             level_q;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             flip;

  assign mismatch = (sync2 != level_q);
  assign flip     = mismatch && (cnt == CNT_W'(DEB_CYCLES - 1));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      if (!mismatch) begin
        cnt <= '0;
      end else if (flip) begin
        cnt     <= '0;
        level_q <= ~level_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Combinational so the top registers pending on the same edge the level flips
  assign rise  = flip & ~level_q;
  assign level = level_q;

endmodule

// File: rtl/io_hub.sv
// rtl/io_hub.sv - memory-mapped LED/switch/confirm-button hub; IOHUB_IRQ_EN adds irq output
module io_hub
  import io_hub_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int IO_W       = 16,
  parameter int N_LED      = 2,
  parameter int N_SW       = 2,
  parameter int DEB_CYCLES = 200000
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  io_read,
  input  logic                  io_write,
  input  logic [DATA_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  input  logic [N_SW*IO_W-1:0]  sw_in,
  input  logic                  btn_in,
  output logic [N_LED*IO_W-1:0] led_out,
  output logic                  btn_pending
`ifdef IOHUB_IRQ_EN
  ,
  output logic                  irq
`endif
);

  logic                  hit;
  logic [9:0]            off;
  logic [N_LED*IO_W-1:0] led_q;
  logic [N_SW*IO_W-1:0]  sw_sync1;
  logic [N_SW*IO_W-1:0]  sw_sync2;
  logic                  pending;
  logic [7:0]            press_cnt;
  logic                  btn_level;
  logic                  btn_rise;
  logic                  ctrl_wr;
  logic                  irq_en;
  logic                  unused_bits;

  assign hit     = (addr[31:10] == IOHUB_HI);
  assign off     = addr[9:0];
  assign ctrl_wr = io_write && hit && (off == IOHUB_CTRL);

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn (
    .clock (clock),
    .rst   (rst),
    .btn_in(btn_in),
    .level (btn_level),
    .rise  (btn_rise)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      led_q <= '0;
    end else if (io_write && hit) begin
      for (int i = 0; i < N_LED; i++) begin
        if (off == IOHUB_LED_BASE + 10'(4 * i)) begin
          led_q[i*IO_W +: IO_W] <= wdata[IO_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sw_sync1 <= '0;
      sw_sync2 <= '0;
    end else begin
      sw_sync1 <= sw_in;
      sw_sync2 <= sw_sync1;
    end
  end

  // A debounced rise on the same edge as a CTRL clear keeps pending set
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pending   <= 1'b0;
      press_cnt <= '0;
    end else begin
      if (btn_rise) begin
        pending   <= 1'b1;
        press_cnt <= press_cnt + 8'd1;
      end else if (ctrl_wr && wdata[CTRL_CLR]) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef IOHUB_IRQ_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en <= wdata[CTRL_IRQ_EN];
      end
      irq <= pending & irq_en;
    end
  end
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (io_read && hit) begin
      for (int i = 0; i < N_LED; i++) begin
        if (off == IOHUB_LED_BASE + 10'(4 * i)) begin
          rdata[IO_W-1:0] = led_q[i*IO_W +: IO_W];
        end
      end
      for (int j = 0; j < N_SW; j++) begin
        if (off == IOHUB_SW_BASE + 10'(4 * j)) begin
          rdata[IO_W-1:0] = sw_sync2[j*IO_W +: IO_W];
        end
      end
      if (off == IOHUB_STATUS) begin
        rdata[ST_PENDING]         = pending;
        rdata[ST_LEVEL]           = btn_level;
        rdata[ST_IRQ_EN]          = irq_en;
        rdata[ST_CNT_LSB +: 8]    = press_cnt;
      end
    end
  end

  assign led_out     = led_q;
  assign btn_pending = pending;
  assign unused_bits = ^{wdata, CTRL_IRQ_EN[0]};

endmodule

// File: tb/tb_io_hub.sv
// tb/tb_io_hub.sv - directed self-checking bench for io_hub with DEB_CYCLES=4
module tb_io_hub;

  localparam logic [31:0] A_LED0   = 32'hFFFFFC60;
  localparam logic [31:0] A_LED1   = 32'hFFFFFC64;
  localparam logic [31:0] A_SW0    = 32'hFFFFFC70;
  localparam logic [31:0] A_SW1    = 32'hFFFFFC74;
  localparam logic [31:0] A_STATUS = 32'hFFFFFC78;
  localparam logic [31:0] A_CTRL   = 32'hFFFFFC7C;

  logic        clock = 1'b0;
  logic        rst;
  logic        io_read;
  logic        io_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] sw_in;
  logic        btn_in;
  logic [31:0] led_out;
  logic        btn_pending;
`ifdef IOHUB_IRQ_EN
  logic        irq;
`endif

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   exp_cnt  = 0;

  always #5 clock = ~clock;

  io_hub #(
    .DATA_W(32), .IO_W(16), .N_LED(2), .N_SW(2), .DEB_CYCLES(4)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .io_read    (io_read),
    .io_write   (io_write),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .sw_in      (sw_in),
    .btn_in     (btn_in),
    .led_out    (led_out),
    .btn_pending(btn_pending)
`ifdef IOHUB_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic cpu_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    addr    = a;
    io_read = 1'b1;
    #1;
    e = sb.pop_front();
    chk(e.tag, rdata, e.exp);
    io_read = 1'b0;
    addr    = '0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    addr     = a;
    wdata    = d;
    io_write = 1'b1;
    @(negedge clock);
    io_write = 1'b0;
    addr     = '0;
    wdata    = '0;
  endtask

  task automatic press();
    btn_in = 1'b1;
    step(8);
    btn_in = 1'b0;
    step(8);
    exp_cnt = (exp_cnt + 1) % 256;
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      io_read  = 1'($urandom);
      io_write = 1'($urandom);
      addr     = {22'h3FFFFF, 10'($urandom_range(16'h60, 16'h7C))};
      wdata    = $urandom;
      sw_in    = $urandom;
      btn_in   = 1'($urandom);
      step(1);
      #1;
      chk("reset_led", led_out, 32'h0);
      chk("reset_pending", {31'h0, btn_pending}, 32'h0);
      chk("reset_rdata", rdata, 32'h0);
    end
    io_read  = 1'b0;
    io_write = 1'b0;
    addr     = '0;
    wdata    = '0;
    sw_in    = '0;
    btn_in   = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    cpu_read("status_after_reset", A_STATUS, 32'h0);

    cpu_write(A_LED1, 32'h1234ABCD);
    chk("led1_write", led_out, 32'hABCD0000);
    cpu_read("led1_read", A_LED1, 32'h0000ABCD);
    cpu_read("led0_read", A_LED0, 32'h0);
    cpu_write(A_LED0, 32'hFFFF5555);
    chk("led0_write", led_out, 32'hABCD5555);
    cpu_write(32'hFFFFFC80, 32'hFFFFFFFF);
    chk("unmapped_write", led_out, 32'hABCD5555);
    cpu_write(32'h7FFFFC60, 32'hFFFFFFFF);
    chk("miss_write", led_out, 32'hABCD5555);
    cpu_write(A_STATUS, 32'hFFFFFFFF);
    chk("status_write_led", led_out, 32'hABCD5555);
    cpu_read("status_write_ign", A_STATUS, 32'h0);
    addr = A_LED1;
    #1;
    chk("no_read_strobe", rdata, 32'h0);
    addr = '0;

    sw_in = 32'h5A5A0000;
    cpu_read("sw1_edge0", A_SW1, 32'h0);
    step(1);
    cpu_read("sw1_edge1", A_SW1, 32'h0);
    step(1);
    cpu_read("sw1_edge2", A_SW1, 32'h00005A5A);
    cpu_read("sw0_edge2", A_SW0, 32'h0);

    for (int i = 0; i < 10; i++) begin
      btn_in = ~btn_in;
      step(1);
      chk("toggle_pending", {31'h0, btn_pending}, 32'h0);
    end
    btn_in = 1'b0;
    step(4);
    cpu_read("toggle_status", A_STATUS, 32'h0);

    btn_in = 1'b1;
    step(5);
    chk("hold_5", {31'h0, btn_pending}, 32'h0);
    step(1);
    chk("hold_6", {31'h0, btn_pending}, 32'h1);
    exp_cnt = 1;
    cpu_read("press1_status", A_STATUS, 32'h00000103);
    cpu_write(A_CTRL, 32'h1);
    chk("ctrl_clear", {31'h0, btn_pending}, 32'h0);
    cpu_read("cleared_status", A_STATUS, 32'h00000102);
    btn_in = 1'b0;
    step(8);
    cpu_read("release_status", A_STATUS, 32'h00000100);

    btn_in = 1'b1;
    step(5);
    cpu_write(A_CTRL, 32'h1);
    exp_cnt = 2;
    chk("collision_pending", {31'h0, btn_pending}, 32'h1);
    cpu_read("collision_status", A_STATUS, 32'h00000203);
    btn_in = 1'b0;
    step(8);

    for (int i = 0; i < 253; i++) press();
    cpu_read("count_255", A_STATUS, {16'h0, 8'(exp_cnt), 8'h01});
    press();
    cpu_read("count_wrap", A_STATUS, {16'h0, 8'(exp_cnt), 8'h01});

`ifdef IOHUB_IRQ_EN
    cpu_write(A_CTRL, 32'h1);
    chk("irq_idle", {31'h0, irq}, 32'h0);
    cpu_write(A_CTRL, 32'h2);
    cpu_read("irq_en_status", A_STATUS, {16'h0, 8'(exp_cnt), 8'h04});
    btn_in = 1'b1;
    step(6);
    exp_cnt = (exp_cnt + 1) % 256;
    chk("irq_pending", {31'h0, btn_pending}, 32'h1);
    chk("irq_lag", {31'h0, irq}, 32'h0);
    step(1);
    chk("irq_set", {31'h0, irq}, 32'h1);
    cpu_write(A_CTRL, 32'h3);
    chk("irq_hold", {31'h0, irq}, 32'h1);
    step(1);
    chk("irq_fall", {31'h0, irq}, 32'h0);
    btn_in = 1'b0;
    step(8);
`else
    cpu_write(A_CTRL, 32'h2);
    cpu_read("ctrl_bit1_ignored", A_STATUS, {16'h0, 8'(exp_cnt), 8'h01});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/io_hub.md
Name: io_hub

Overview:
Parametrised memory-mapped IO subsystem for the minisys CPU, replacing the single-channel switch-read and LED-write pair. It decodes the CPU's IO address window and drives N_LED LED banks and N_SW switch banks. It adds input synchronisation and a debounced confirm-button event latch with a press counter, so software can poll for user confirmation. It sits between the CPU's MemOrIO path (io_read, io_write, ALU address, register write data) and the board pins.

Parameters:
DATA_W, 32, CPU data and address width
IO_W, 16, width of one LED or switch bank (IO_W <= DATA_W)
N_LED, 2, number of LED banks (1..4)
N_SW, 2, number of switch banks (1..2)
DEB_CYCLES, 200000, consecutive stable cycles required to accept a button level change (>= 2)

Ports:
clock  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-low reset
io_read  input  1  CPU IO read strobe
io_write  input  1  CPU IO write strobe
addr  input  DATA_W  CPU byte address (ALU result)
wdata  input  DATA_W  CPU write data
rdata  output  DATA_W  read data returned to CPU
sw_in  input  N_SW*IO_W  raw switch pins; bank j occupies bits [j*IO_W +: IO_W]
btn_in  input  1  raw confirm button, active high
led_out  output  N_LED*IO_W  LED pins; bank i occupies bits [i*IO_W +: IO_W]
btn_pending  output  1  sticky confirm-event flag

Behaviour:
- Address decode: a hit requires addr[31:10] == 22'h3FFFFF. Offset is addr[9:0].
- Register map:
  - LED bank i at 0x060+4i (read/write, IO_W bits).
  - Switch bank j at 0x070+4j (read-only).
  - STATUS at 0x078 (RO): bit0 = pending, bit1 = debounced button level, bits[15:8] = press count.
  - CTRL at 0x07C (WO): writing with bit0 = 1 clears pending.
- Writes:
  - Take effect on the clock edge when io_write is high and the offset hits.
  - LED bank takes wdata[IO_W-1:0].
  - Writes to unmapped offsets, switch banks or STATUS are ignored.
- Reads:
  - rdata is combinational from registered state, zero-extended to DATA_W.
  - rdata = 0 when io_read is low, the address misses, or the offset is unmapped.
  - A read has no side effects.
- Switches: 2-flop synchroniser per bit. Read value lags the pins by 2 cycles. Not debounced.
- Button:
  - 2-flop synchroniser feeds the debounce counter.
  - While the synchronised level differs from the debounced level, the counter increments. Any cycle where they match resets the counter to 0.
  - When the counter reaches DEB_CYCLES-1 with a mismatch still present, the debounced level flips and the counter clears.
  - Net latency from a clean pin edge to the debounced flip: DEB_CYCLES+2 cycles.
  - A debounced rising edge sets pending and increments the 8-bit press count; the count wraps 255 to 0.
  - Falling edges only update the level.
- Simultaneous pending set and CTRL clear in one cycle: set wins, pending stays 1.
- btn_pending mirrors the pending register.
- Reset (async assert, synchronous deassert handled by the top level): all LED banks 0, synchronisers 0, debounced level 0, counter 0, pending 0, press count 0. Therefore led_out = 0, btn_pending = 0, rdata = 0.
- Reset mid-debounce discards the partial count.

Optional Feature:
IOHUB_IRQ_EN
- Defined:
  - Adds output irq (1 bit) and an interrupt-enable bit written via CTRL bit1, reset 0.
  - STATUS bit2 reads back the enable.
  - irq = pending & enable, registered with 1-cycle latency.
- Undefined:
  - No irq port; CTRL bit1 is ignored; STATUS bit2 reads 0.

Decomposition:
- Shared package/header: IO window high-address constant 22'h3FFFFF; offsets IOHUB_LED_BASE 0x060, IOHUB_SW_BASE 0x070, IOHUB_STATUS 0x078, IOHUB_CTRL 0x07C; STATUS/CTRL bit indices.
- One sub-module: btn_debounce (synchroniser, counter, level, rise pulse), parametrised by DEB_CYCLES.

Test Plan (DEB_CYCLES=4):
- Reset: hold rst=0 with random inputs -> led_out=0, btn_pending=0, rdata=0. Release, then read STATUS at 0xFFFFFC78 -> 0x00000000.
- LED write/readback: write 0x1234ABCD to 0xFFFFFC64 -> led_out[31:16]=0xABCD, bank0 unchanged. Read 0xFFFFFC64 -> 0x0000ABCD. Write to 0xFFFFFC80 -> no change. Write with addr[31:10] != all-ones -> no change.
- Switch sync: sw_in bank1 set to 0x5A5A -> a read of 0xFFFFFC74 returns 0x00005A5A no earlier than the 2nd edge after the change.
- Debounce: btn_in toggles high/low each cycle for 10 cycles -> pending stays 0. Then held high -> pending=1 and count=1 exactly 6 cycles after the hold starts. Write CTRL 0x1 -> pending=0.
- Set/clear collision: align the CTRL clear write with the debounced rising edge -> pending stays 1. 256 presses -> count wraps to 0.
- IOHUB_IRQ_EN build: write CTRL 0x2, then press -> irq=1 one cycle after pending. Write CTRL 0x3 -> irq falls on the following cycle.
